skullfet_bist: RTL and testbench

- Parametrised built-in self-test sequencer for an array of SkullFET logic cells (inverters and 2-input NANDs) placed next to it in user_project_wrapper.
- Drives pseudo-random A/B stimulus into NUM_CH cells and waits a programmable settle time, since SkullFET cells are slow.
- Samples each cell output against a golden model and keeps saturating per-channel mismatch counters.
- Successor to the fixed one-inverter/one-NAND pin hookup: adds channel count, cell-type mix, vector count and self-checking.

---
 rtl/skullfet_bist_pkg.sv | 14 +
 rtl/skullfet_bist_lfsr.sv | 23 ++
 rtl/skullfet_bist.sv | 160 ++++++++++++++++
 tb/tb_skullfet_bist.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/skullfet_bist_pkg.sv
// Shared types and constants for the SkullFET cell BIST sequencer.
package skullfet_bist_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Width of a counter that must hold the values 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/skullfet_bist_lfsr.sv
// 16-bit right-shifting Galois LFSR that produces the BIST stimulus sequence.
module skullfet_bist_lfsr
  import skullfet_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  output logic [15:0] state,
  output logic [15:0] next
);

  assign next = state[0] ? ((state >> 1) ^ LFSR_POLY) : (state >> 1);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      state <= LFSR_SEED;
    end else if (step) begin
      state <= next;
    end
  end

endmodule

// File: rtl/skullfet_bist.sv
// BIST sequencer driving pseudo-random vectors into SkullFET inverter/NAND cells.
// Define SKULLFET_BIST_FAIL_CAPTURE_EN to add first-failure capture outputs.
module skullfet_bist
  import skullfet_bist_pkg::*;
#(
  parameter int                NUM_CH       = 4,
  parameter logic [NUM_CH-1:0] CH_NAND_MASK = 4'b1010,
  parameter int                NUM_VEC      = 256,
  parameter int                SETTLE_CYC   = 4,
  parameter int                CNT_W        = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [NUM_CH-1:0] cell_a_o,
  output logic [NUM_CH-1:0] cell_b_o,
  input  logic [NUM_CH-1:0] cell_y_i,
  input  logic [2:0]        err_sel_i,
  output logic [CNT_W-1:0]  err_cnt_o
`ifdef SKULLFET_BIST_FAIL_CAPTURE_EN
  ,
  output logic              fail_seen_o,
  output logic [15:0]       fail_vec_o,
  output logic [2:0]        fail_ch_o
`endif
);

  localparam int VW = idx_width(NUM_VEC);
  localparam int TW = idx_width(SETTLE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic [VW-1:0]     vec_idx;
  logic [TW-1:0]     timer;
  logic [CNT_W-1:0]  err_cnt [NUM_CH];
  logic [15:0]       lfsr_q, lfsr_next;
  logic              start_ok, last_vec;
  logic [NUM_CH-1:0] expected, mismatch;
  logic              unused_lfsr_bits;

  function automatic logic [NUM_CH-1:0] vec_a(input logic [15:0] v);
    return v[NUM_CH-1:0];
  endfunction

  function automatic logic [NUM_CH-1:0] vec_b(input logic [15:0] v);
    return v[NUM_CH+7:8] & CH_NAND_MASK;
  endfunction

  assign start_ok = start_i && ((state == IDLE) || (state == DONE));
  assign last_vec = (vec_idx == VW'(NUM_VEC - 1));

  skullfet_bist_lfsr u_lfsr (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .load  (start_ok),
    .step  ((state == SAMPLE) && !last_vec),
    .state (lfsr_q),
    .next  (lfsr_next)
  );

  // Only a slice of the LFSR feeds the cells; the rest is intentionally dropped.
  assign unused_lfsr_bits = ^{lfsr_q, lfsr_next};

  // Inverter channels force their B term to 1 so the NAND form collapses to ~A.
  assign expected = ~(cell_a_o & (cell_b_o | ~CH_NAND_MASK));
  assign mismatch = cell_y_i ^ expected;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      vec_idx  <= '0;
      timer    <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      cell_a_o <= '0;
      cell_b_o <= '0;
      for (int i = 0; i < NUM_CH; i++) err_cnt[i] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            for (int i = 0; i < NUM_CH; i++) err_cnt[i] <= '0;
            cell_a_o <= vec_a(LFSR_SEED);
            cell_b_o <= vec_b(LFSR_SEED);
            vec_idx  <= '0;
            timer    <= TW'(SETTLE_CYC - 1);
            busy_o   <= 1'b1;
            done_o   <= 1'b0;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (timer == '0) state <= SAMPLE;
          else             timer <= timer - 1'b1;
        end
        SAMPLE: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (mismatch[i] && (err_cnt[i] != CNT_MAX)) err_cnt[i] <= err_cnt[i] + 1'b1;
          end
          if (last_vec) begin
            cell_a_o <= '0;
            cell_b_o <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
            state    <= DONE;
          end else begin
            cell_a_o <= vec_a(lfsr_next);
            cell_b_o <= vec_b(lfsr_next);
            vec_idx  <= vec_idx + 1'b1;
            timer    <= TW'(SETTLE_CYC - 1);
            state    <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    pass_o = (state == DONE);
    for (int i = 0; i < NUM_CH; i++) begin
      if (err_cnt[i] != '0) pass_o = 1'b0;
    end
  end

  always_comb begin
    err_cnt_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (err_sel_i == 3'(i)) err_cnt_o = err_cnt[i];
    end
  end

`ifdef SKULLFET_BIST_FAIL_CAPTURE_EN
  logic [2:0] first_ch;

  // Scanning downward leaves the lowest mismatching channel as the winner.
  always_comb begin
    first_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mismatch[i]) first_ch = 3'(i);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || start_ok) begin
      fail_seen_o <= 1'b0;
      fail_vec_o  <= '0;
      fail_ch_o   <= '0;
    end else if ((state == SAMPLE) && (|mismatch) && !fail_seen_o) begin
      fail_seen_o <= 1'b1;
      fail_vec_o  <= 16'(vec_idx);
      fail_ch_o   <= first_ch;
    end
  end
`endif

endmodule

// File: tb/tb_skullfet_bist.sv
// Bench for skullfet_bist: random cell faults checked against an LFSR vector-table model.
module tb_skullfet_bist;

  localparam int NUM_VEC = 16;
  localparam int SETTLE  = 4;
  localparam int PER_VEC = SETTLE + 1;
  localparam int RUN_CYC = NUM_VEC * PER_VEC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  nand_m = 4'b1010;
  logic [15:0] vecs [NUM_VEC];

  logic        busy, done, pass;
  logic [3:0]  a, b, y;
  logic [2:0]  sel = '0;
  logic [15:0] cnt;
  logic [3:0]  f0 = '0, f1 = '0, finv = '0;

  logic        s_busy, s_done, s_pass;
  logic [3:0]  s_a, s_b, s_y;
  logic [2:0]  s_sel = '0;
  logic [2:0]  s_cnt;
  logic [3:0]  sf0 = '0, sf1 = '0, sfinv = '0;

  logic        l_load = 1'b0, l_step = 1'b0;
  logic [15:0] l_state, l_next;

  int checks = 0;
  int failures = 0;
  logic [3:0] obs_a [0:RUN_CYC];
  logic [3:0] obs_b [0:RUN_CYC];
  logic busy_at_start;
  logic seen_at_start;

`ifdef SKULLFET_BIST_FAIL_CAPTURE_EN
  logic fseen, s_fseen;
  logic [15:0] fvec, s_fvec;
  logic [2:0] fch, s_fch;
`endif

  skullfet_bist #(.NUM_CH(4), .CH_NAND_MASK(4'b1010), .NUM_VEC(NUM_VEC),
                  .SETTLE_CYC(SETTLE), .CNT_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
    .pass_o(pass), .cell_a_o(a), .cell_b_o(b), .cell_y_i(y), .err_sel_i(sel),
    .err_cnt_o(cnt)
`ifdef SKULLFET_BIST_FAIL_CAPTURE_EN
    , .fail_seen_o(fseen), .fail_vec_o(fvec), .fail_ch_o(fch)
`endif
  );

  skullfet_bist #(.NUM_CH(4), .CH_NAND_MASK(4'b1010), .NUM_VEC(NUM_VEC),
                  .SETTLE_CYC(SETTLE), .CNT_W(3)) dut_sat (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .busy_o(s_busy), .done_o(s_done),
    .pass_o(s_pass), .cell_a_o(s_a), .cell_b_o(s_b), .cell_y_i(s_y), .err_sel_i(s_sel),
    .err_cnt_o(s_cnt)
`ifdef SKULLFET_BIST_FAIL_CAPTURE_EN
    , .fail_seen_o(s_fseen), .fail_vec_o(s_fvec), .fail_ch_o(s_fch)
`endif
  );

  skullfet_bist_lfsr u_ref_lfsr (
    .clk(clk), .rst(rst), .load(l_load), .step(l_step), .state(l_state), .next(l_next)
  );

  // Zero-delay cell array with stuck-at-0, stuck-at-1 and Y=A faults.
  function automatic logic [3:0] cell_out(input logic [3:0] ca, input logic [3:0] cb,
                                          input logic [3:0] s0, input logic [3:0] s1,
                                          input logic [3:0] inv);
    logic [3:0] yv;
    for (int i = 0; i < 4; i++) begin
      if (s0[i])          yv[i] = 1'b0;
      else if (s1[i])     yv[i] = 1'b1;
      else if (inv[i])    yv[i] = ca[i];
      else if (nand_m[i]) yv[i] = !(ca[i] && cb[i]);
      else                yv[i] = !ca[i];
    end
    return yv;
  endfunction

  assign y   = cell_out(a, b, f0, f1, finv);
  assign s_y = cell_out(s_a, s_b, sf0, sf1, sfinv);

  function automatic logic [15:0] lfsr_advance(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic bit golden_y(input int k, input int ch);
    bit ai = vecs[k][ch];
    bit bi = nand_m[ch] && vecs[k][ch + 8];
    return nand_m[ch] ? !(ai && bi) : !ai;
  endfunction

  function automatic bit faulty_y(input int k, input int ch, input logic [3:0] s0,
                                  input logic [3:0] s1, input logic [3:0] inv);
    if (s0[ch]) return 1'b0;
    if (s1[ch]) return 1'b1;
    if (inv[ch]) return vecs[k][ch];
    return golden_y(k, ch);
  endfunction

  function automatic int exp_count(input int ch, input logic [3:0] s0, input logic [3:0] s1,
                                   input logic [3:0] inv, input int maxv);
    int n = 0;
    for (int k = 0; k < NUM_VEC; k++) begin
      if (faulty_y(k, ch, s0, s1, inv) != golden_y(k, ch)) n++;
    end
    return (n > maxv) ? maxv : n;
  endfunction

  // Starts a run (optionally re-pulsing start at a given cycle) and waits for done.
  task automatic run_bist(input int restart_at, output int cycles, output bit tmo);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    cycles = 0;
    tmo = 1'b0;
    obs_a[0] = a;
    obs_b[0] = b;
    busy_at_start = busy;
`ifdef SKULLFET_BIST_FAIL_CAPTURE_EN
    seen_at_start = fseen;
`else
    seen_at_start = 1'b0;
`endif
    while (!done) begin
      start = (cycles == restart_at);
      @(posedge clk);
      @(negedge clk);
      cycles++;
      if (cycles <= RUN_CYC) begin
        obs_a[cycles] = a;
        obs_b[cycles] = b;
      end
      if (cycles > 4 * RUN_CYC) begin
        tmo = 1'b1;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, pass} !== 3'b000) begin
      failures++; $display("[TB] FAIL reset_flags: got %b expected 000", {busy, done, pass});
    end
    checks++;
    if ({a, b} !== 8'h00) begin
      failures++; $display("[TB] FAIL reset_cells: got a=%h b=%h expected 0", a, b);
    end
    checks++;
    if ({s_busy, s_done, s_pass, s_a, s_b} !== 11'h000) begin
      failures++; $display("[TB] FAIL reset_sat: got %h expected 0", {s_busy, s_done, s_pass, s_a, s_b});
    end
    for (int ch = 0; ch < 8; ch++) begin
      @(negedge clk); sel = 3'(ch); #1;
      checks++;
      if (cnt !== 16'h0) begin
        failures++; $display("[TB] FAIL reset_cnt%0d: got %0d expected 0", ch, cnt);
      end
    end
`ifdef SKULLFET_BIST_FAIL_CAPTURE_EN
    checks++;
    if ({fseen, fvec, fch} !== 20'h0) begin
      failures++; $display("[TB] FAIL reset_capture: got %b/%0d/%0d expected 0", fseen, fvec, fch);
    end
`endif
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_lfsr_model();
    @(negedge clk); l_load = 1'b1;
    @(negedge clk); l_load = 1'b0; l_step = 1'b1;
    for (int k = 0; k < NUM_VEC; k++) begin
      checks++;
      if (l_state !== vecs[k]) begin
        failures++; $display("[TB] FAIL lfsr_vec%0d: got %h expected %h", k, l_state, vecs[k]);
      end
      @(negedge clk);
    end
    l_step = 1'b0;
  endtask

  task automatic test_ideal();
    int cyc;
    bit tmo;
    f0 = '0; f1 = '0; finv = '0; sf0 = '0; sf1 = '0; sfinv = '0;
    run_bist(-1, cyc, tmo);
    checks++;
    if (tmo || cyc != RUN_CYC) begin
      failures++; $display("[TB] FAIL ideal_done_time: got %0d timeout=%0d expected %0d", cyc, tmo, RUN_CYC);
    end
    checks++;
    if (busy_at_start !== 1'b1) begin
      failures++; $display("[TB] FAIL ideal_busy_rise: got %b expected 1", busy_at_start);
    end
    checks++;
    if ({busy, done, pass, a, b} !== {3'b011, 8'h00}) begin
      failures++; $display("[TB] FAIL ideal_end_state: got %b%b%b a=%h b=%h expected 011 a=0 b=0", busy, done, pass, a, b);
    end
    for (int k = 0; k < NUM_VEC; k++) begin
      logic [15:0] v;
      v = vecs[k];
      checks++;
      if (obs_a[k * PER_VEC + SETTLE] !== v[3:0] || obs_b[k * PER_VEC + SETTLE] !== (v[11:8] & nand_m)) begin
        failures++;
        $display("[TB] FAIL ideal_stim%0d: got a=%h b=%h expected a=%h b=%h", k,
                 obs_a[k * PER_VEC + SETTLE], obs_b[k * PER_VEC + SETTLE], v[3:0], v[11:8] & nand_m);
      end
    end
    for (int ch = 0; ch < 4; ch++) begin
      @(negedge clk); sel = 3'(ch); #1;
      checks++;
      if (cnt !== 16'h0) begin
        failures++; $display("[TB] FAIL ideal_cnt%0d: got %0d expected 0", ch, cnt);
      end
    end
  endtask

  task automatic test_faults();
    int cyc;
    bit tmo;
    f0 = 4'b0010; f1 = '0; finv = '0;
    sf0 = '0; sf1 = '0; sfinv = 4'b0001;
    run_bist(-1, cyc, tmo);
    checks++;
    if (tmo || cyc != RUN_CYC) begin
      failures++; $display("[TB] FAIL fault_done_time: got %0d expected %0d", cyc, RUN_CYC);
    end
    checks++;
    if (pass !== 1'b0 || s_pass !== 1'b0) begin
      failures++; $display("[TB] FAIL fault_pass: got %b/%b expected 0/0", pass, s_pass);
    end
    for (int ch = 0; ch < 4; ch++) begin
      logic [15:0] e;
      logic [2:0]  se;
      e  = 16'(exp_count(ch, f0, f1, finv, 65535));
      se = 3'(exp_count(ch, sf0, sf1, sfinv, 7));
      @(negedge clk); sel = 3'(ch); s_sel = 3'(ch); #1;
      checks++;
      if (cnt !== e) begin
        failures++; $display("[TB] FAIL stuck0_cnt%0d: got %0d expected %0d", ch, cnt, e);
      end
      checks++;
      if (s_cnt !== se) begin
        failures++; $display("[TB] FAIL sat_cnt%0d: got %0d expected %0d", ch, s_cnt, se);
      end
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    bit tmo;
    logic [15:0] e;
    f0 = 4'b0010; f1 = '0; finv = '0;
    run_bist(3 * PER_VEC + 2, cyc, tmo);
    checks++;
    if (tmo || cyc != RUN_CYC) begin
      failures++; $display("[TB] FAIL ignored_start_time: got %0d expected %0d", cyc, RUN_CYC);
    end
    e = 16'(exp_count(1, f0, f1, finv, 65535));
    @(negedge clk); sel = 3'd1; #1;
    checks++;
    if (cnt !== e) begin
      failures++; $display("[TB] FAIL ignored_start_cnt1: got %0d expected %0d", cnt, e);
    end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    bit tmo;
    logic [15:0] e;
    f0 = 4'b0010; f1 = '0; finv = '0;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (5 * PER_VEC + 2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, pass, a, b} !== 11'h000) begin
      failures++; $display("[TB] FAIL midrun_reset_state: got %b%b%b a=%h b=%h expected all 0", busy, done, pass, a, b);
    end
    for (int ch = 0; ch < 4; ch++) begin
      @(negedge clk); sel = 3'(ch); #1;
      checks++;
      if (cnt !== 16'h0) begin
        failures++; $display("[TB] FAIL midrun_reset_cnt%0d: got %0d expected 0", ch, cnt);
      end
    end
    @(negedge clk); rst = 1'b0;
    run_bist(-1, cyc, tmo);
    checks++;
    if (tmo || cyc != RUN_CYC) begin
      failures++; $display("[TB] FAIL restart_time: got %0d expected %0d", cyc, RUN_CYC);
    end
    e = 16'(exp_count(1, f0, f1, finv, 65535));
    @(negedge clk); sel = 3'd1; #1;
    checks++;
    if (cnt !== e) begin
      failures++; $display("[TB] FAIL restart_cnt1: got %0d expected %0d", cnt, e);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int cyc;
      bit tmo;
      bit all_zero;
      f0    = 4'($urandom_range(0, 15));
      f1    = 4'($urandom_range(0, 15)) & ~f0;
      finv  = 4'($urandom_range(0, 15)) & ~(f0 | f1);
      sf0   = 4'($urandom_range(0, 15));
      sf1   = 4'($urandom_range(0, 15)) & ~sf0;
      sfinv = 4'($urandom_range(0, 15)) & ~(sf0 | sf1);
      run_bist(-1, cyc, tmo);
      checks++;
      if (tmo || cyc != RUN_CYC) begin
        failures++; $display("[TB] FAIL rand%0d_time: got %0d expected %0d", it, cyc, RUN_CYC);
      end
      all_zero = 1'b1;
      for (int ch = 0; ch < 4; ch++) begin
        logic [15:0] e;
        logic [2:0]  se;
        e  = 16'(exp_count(ch, f0, f1, finv, 65535));
        se = 3'(exp_count(ch, sf0, sf1, sfinv, 7));
        if (e != 0) all_zero = 1'b0;
        @(negedge clk); sel = 3'(ch); s_sel = 3'(ch); #1;
        checks++;
        if (cnt !== e || s_cnt !== se) begin
          failures++;
          $display("[TB] FAIL rand%0d_cnt%0d: got %0d/%0d expected %0d/%0d", it, ch, cnt, s_cnt, e, se);
        end
      end
      checks++;
      if (pass !== all_zero) begin
        failures++; $display("[TB] FAIL rand%0d_pass: got %b expected %b", it, pass, all_zero);
      end
      @(negedge clk); sel = 3'($urandom_range(4, 7)); #1;
      checks++;
      if (cnt !== 16'h0) begin
        failures++; $display("[TB] FAIL rand%0d_sel_oob: got %0d expected 0", it, cnt);
      end
`ifdef SKULLFET_BIST_FAIL_CAPTURE_EN
      begin
        bit found;
        int fk, fc;
        found = 1'b0; fk = 0; fc = 0;
        for (int k = 0; k < NUM_VEC && !found; k++) begin
          for (int ch = 3; ch >= 0; ch--) begin
            if (faulty_y(k, ch, f0, f1, finv) != golden_y(k, ch)) begin
              found = 1'b1; fk = k; fc = ch;
            end
          end
        end
        checks++;
        if (fseen !== found || (found && (fvec !== 16'(fk) || fch !== 3'(fc)))) begin
          failures++;
          $display("[TB] FAIL rand%0d_capture: got %b/%0d/%0d expected %b/%0d/%0d", it, fseen, fvec, fch, found, fk, fc);
        end
      end
`endif
    end
  endtask

`ifdef SKULLFET_BIST_FAIL_CAPTURE_EN
  task automatic test_capture();
    int cyc;
    bit tmo;
    bit found;
    int fk, fc;
    f0 = '0; f1 = 4'b1100; finv = '0;
    found = 1'b0; fk = 0; fc = 3;
    for (int k = 0; k < NUM_VEC && !found; k++) begin
      if (!golden_y(k, 2) || !golden_y(k, 3)) begin
        found = 1'b1; fk = k; fc = !golden_y(k, 2) ? 2 : 3;
      end
    end
    run_bist(-1, cyc, tmo);
    checks++;
    if (tmo || fseen !== found || fvec !== 16'(fk) || fch !== 3'(fc)) begin
      failures++;
      $display("[TB] FAIL capture_stuck1: got %b/%0d/%0d expected %b/%0d/%0d", fseen, fvec, fch, found, fk, fc);
    end
    f1 = '0;
    run_bist(-1, cyc, tmo);
    checks++;
    if (seen_at_start !== 1'b0 || fseen !== 1'b0) begin
      failures++; $display("[TB] FAIL capture_clear: got %b/%b expected 0/0", seen_at_start, fseen);
    end
  endtask
`endif

  initial begin
    vecs[0] = 16'hACE1;
    for (int k = 1; k < NUM_VEC; k++) vecs[k] = lfsr_advance(vecs[k - 1]);
    test_reset();
    test_lfsr_model();
    test_ideal();
    test_faults();
    test_start_ignored();
    test_reset_midrun();
    test_random();
`ifdef SKULLFET_BIST_FAIL_CAPTURE_EN
    test_capture();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
